mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 27 ++
 rtl/mem_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, data and byte-RAM signals between requesters/RAM and the memory controller
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_len;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        busy;
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_len, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, busy
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_len, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by instruction fetch and data access; MEMCTRL_RR_EN selects round-robin arbitration
module mem_ctrl (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]  state;
  logic [2:0]  cnt, n, cnt_eff, req_n;
  logic [1:0]  idx;
  logic [31:0] base, wdata, asm_q, asm_next, addr_q, cur_addr, if_data_q, mem_rdata_q;
  logic        we, gnt_mem, any_req, pick_mem;
  assign any_req = bus.mem_req | bus.if_req;
`ifdef MEMCTRL_RR_EN
  logic last_mem;
  assign pick_mem = bus.mem_req && (!bus.if_req || !last_mem);
  always_ff @(posedge clk)
    if (rst) last_mem <= 1'b0;
    else if (state == IDLE && any_req) last_mem <= pick_mem;
`else
  assign pick_mem = bus.mem_req;
`endif
  assign req_n = bus.mem_len == 2'd0 ? 3'd1 : bus.mem_len == 2'd1 ? 3'd2 : 3'd4;
  // a read's final cycle (cnt == n) only collects the last byte, so the address stays put
  assign cnt_eff  = cnt == n ? cnt - 3'd1 : cnt;
  assign cur_addr = base + {29'd0, cnt_eff};
  assign idx      = cnt[1:0] - 2'd1;
  assign asm_next = asm_q | ({24'd0, bus.ram_din} << {idx, 3'b000});
  assign bus.ram_addr  = state == BUSY ? cur_addr : addr_q;
  assign bus.ram_wr    = state == BUSY && we;
  assign bus.ram_dout  = state == BUSY && we ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
  assign bus.busy      = state != IDLE;
  assign bus.if_done   = state == DONE && !gnt_mem;
  assign bus.mem_done  = state == DONE && gnt_mem;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      n           <= 3'd0;
      base        <= 32'd0;
      wdata       <= 32'd0;
      we          <= 1'b0;
      gnt_mem     <= 1'b0;
      asm_q       <= 32'd0;
      addr_q      <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      if (state == BUSY) addr_q <= cur_addr;
      if (state == IDLE) begin
        if (any_req) begin
          gnt_mem <= pick_mem;
          base    <= pick_mem ? bus.mem_addr : bus.if_addr;
          n       <= pick_mem ? req_n : 3'd4;
          we      <= pick_mem && bus.mem_we;
          wdata   <= pick_mem ? bus.mem_wdata : 32'd0;
          cnt     <= 3'd0;
          asm_q   <= 32'd0;
          state   <= BUSY;
        end
      end else if (state == BUSY) begin
        if (we) begin
          cnt <= cnt + 3'd1;
          if (cnt == n - 3'd1) state <= DONE;
        end else begin
          if (cnt != 3'd0) asm_q <= asm_next;
          if (cnt == n) begin
            state <= DONE;
            if (gnt_mem) mem_rdata_q <= asm_next;
            else if_data_q <= asm_next;
          end else cnt <= cnt + 3'd1;
        end
      end else state <= IDLE;
    end
endmodule
